// File: rtl/resource_arbiter.sv
`default_nettype none
//============================================================================
// Module   : resource_arbiter
// Two-lane arbiter for a fixed-latency shared resource, with hold-limited
// rotation and per-lane flush of in-flight responses.
// Revision : 1.0
//============================================================================
module resource_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int LATENCY  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic        flush0,
    input  logic        flush1,
    output logic        grant0,
    output logic        grant1,
    output logic        res_valid,
    output logic [31:0] res_data,
    input  logic [31:0] res_result,
    output logic [31:0] rsp_data,
    output logic        rsp_valid0,
    output logic        rsp_valid1
);

    localparam int                    c_hold_w   = $clog2(MAX_HOLD) + 1;
    localparam logic [c_hold_w-1:0]   c_hold_max = c_hold_w'(MAX_HOLD - 1);
    localparam logic [c_hold_w-1:0]   c_hold_one = c_hold_w'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT0 = 2'd1,
        S_GRANT1 = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [c_hold_w-1:0]   hold_cnt_q, hold_cnt_d;
    logic                  last_q, last_d;
    logic [LATENCY-1:0]    tag_vld_q, tag_vld_d;
    logic [LATENCY-1:0]    tag_id_q, tag_id_d;

    logic w_eff_req0, w_eff_req1;
    logic w_issue0, w_issue1;
    logic w_out_vld, w_out_id;

    // A request flushed in the same cycle does not compete for the resource.
    assign w_eff_req0 = req0 & ~flush0;
    assign w_eff_req1 = req1 & ~flush1;

    assign grant0 = (state_q == S_GRANT0);
    assign grant1 = (state_q == S_GRANT1);

    assign w_issue0  = grant0 & w_eff_req0;
    assign w_issue1  = grant1 & w_eff_req1;
    assign res_valid = w_issue0 | w_issue1;
    assign res_data  = w_issue0 ? data0 : (w_issue1 ? data1 : 32'd0);

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        last_d     = last_q;
        case (state_q)
            S_IDLE: begin
                if (w_eff_req0 && w_eff_req1) state_d = last_q ? S_GRANT0 : S_GRANT1;
                else if (w_eff_req0)          state_d = S_GRANT0;
                else if (w_eff_req1)          state_d = S_GRANT1;
            end
            S_GRANT0: begin
                if (!w_eff_req0)                              state_d = w_eff_req1 ? S_GRANT1 : S_IDLE;
                else if (hold_cnt_q == c_hold_max && w_eff_req1) state_d = S_GRANT1;
                else if (hold_cnt_q != c_hold_max)            hold_cnt_d = hold_cnt_q + c_hold_one;
            end
            S_GRANT1: begin
                if (!w_eff_req1)                              state_d = w_eff_req0 ? S_GRANT0 : S_IDLE;
                else if (hold_cnt_q == c_hold_max && w_eff_req0) state_d = S_GRANT0;
                else if (hold_cnt_q != c_hold_max)            hold_cnt_d = hold_cnt_q + c_hold_one;
            end
            default: state_d = S_IDLE;
        endcase
        // Every fresh grant restarts the hold window and records the owner.
        if (state_d != state_q && state_d == S_GRANT0) begin
            hold_cnt_d = '0;
            last_d     = 1'b0;
        end else if (state_d != state_q && state_d == S_GRANT1) begin
            hold_cnt_d = '0;
            last_d     = 1'b1;
        end
    end

    // Tag pipeline mirrors the resource latency; a lane flush kills its own
    // entries wherever they sit, including the one leaving the last stage.
    always_comb begin
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = res_valid;
        tag_id_d[0]  = w_issue1;
        for (int i = 1; i < LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1] & ~(tag_id_q[i-1] ? flush1 : flush0);
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    assign w_out_vld  = tag_vld_q[LATENCY-1];
    assign w_out_id   = tag_id_q[LATENCY-1];
    assign rsp_valid0 = w_out_vld & ~w_out_id & ~flush0;
    assign rsp_valid1 = w_out_vld &  w_out_id & ~flush1;
    assign rsp_data   = (rsp_valid0 | rsp_valid1) ? res_result : 32'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            hold_cnt_q <= '0;
            last_q     <= 1'b1;
            tag_vld_q  <= '0;
            tag_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            last_q     <= last_d;
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
        end
    end

endmodule
`default_nettype wire
